// File: rtl/mdc_acondicionador_entradas.sv
// Input conditioning for the coffee-machine controller: per-channel two-flop sync,
// debounce and button latching, producing registered active-low Condicion levels.
module mdc_acondicionador_entradas #(
  parameter int              N_CH      = 6,
  parameter int              DB_CYCLES = 4,
  parameter logic [N_CH-1:0] BTN_MASK  = 6'b001100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_n,
  input  logic            clr_req,
  output logic [N_CH-1:0] cond_n,
  output logic            cambio
);

  localparam int              CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_CH-1:0] cond_next;
  logic [N_CH-1:0] cond_n_reg;
  logic            cambio_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi = gi + 1) begin : g_ch
      logic             s1_reg;
      logic             s2_reg;
      logic             stable_reg;
      logic             stable_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;

      // A new level is accepted only after DB_CYCLES consecutive disagreeing samples.
      always_comb begin
        stable_next = stable_reg;
        cnt_next    = '0;
        if (s2_reg != stable_reg) begin
          if (cnt_reg == CNT_MAX) begin
            stable_next = s2_reg;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg     <= 1'b1;
          s2_reg     <= 1'b1;
          stable_reg <= 1'b1;
          cnt_reg    <= '0;
        end else begin
          s1_reg     <= raw_n[gi];
          s2_reg     <= s1_reg;
          stable_reg <= stable_next;
          cnt_reg    <= cnt_next;
        end
      end

      if (BTN_MASK[gi]) begin : g_btn
        logic latch_reg;
        logic latch_next;
        logic press;

        // A press landing on the same edge as a clear still sets the latch.
        assign press = stable_reg & ~stable_next;

        always_comb begin
          latch_next = latch_reg;
          if (clr_req) begin
            latch_next = 1'b0;
          end
          if (press) begin
            latch_next = 1'b1;
          end
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            latch_reg <= 1'b0;
          end else begin
            latch_reg <= latch_next;
          end
        end

        assign cond_next[gi] = ~latch_next;
      end else begin : g_lvl
        assign cond_next[gi] = stable_next;
      end
    end
  endgenerate

  // cond_n is registered from next-state values so it moves on the same edge as the
  // debounced level; cambio flags the first cycle a new value is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      cond_n_reg <= {N_CH{1'b1}};
      cambio_reg <= 1'b0;
    end else begin
      cond_n_reg <= cond_next;
      cambio_reg <= |(cond_next ^ cond_n_reg);
    end
  end

  assign cond_n = cond_n_reg;
  assign cambio = cambio_reg;

endmodule

// File: tb/tb_mdc_acondicionador_entradas.sv
// Directed and randomized bench for mdc_acondicionador_entradas against a
// sliding-window behavioural model of sync + debounce + button latching.
module tb_mdc_acondicionador_entradas;

  localparam int         N_CH = 6;
  localparam int         DB   = 4;
  localparam logic [5:0] BTN  = 6'b001100;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] raw_n;
  logic            clr_req;
  logic [N_CH-1:0] cond_n;
  logic            cambio;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: hist[j] holds the raw value sampled j edges ago (hist[0] = this edge).
  logic [N_CH-1:0] hist [0:DB+1];
  logic [N_CH-1:0] m_stable;
  logic [N_CH-1:0] m_latch;
  logic [N_CH-1:0] m_cond;
  logic            m_cambio;

  mdc_acondicionador_entradas #(
    .N_CH(N_CH), .DB_CYCLES(DB), .BTN_MASK(BTN)
  ) dut (
    .clk(clk), .rst(rst), .raw_n(raw_n), .clr_req(clr_req),
    .cond_n(cond_n), .cambio(cambio)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    logic [N_CH-1:0] ns, nl, nc;
    logic            all_diff;
    @(posedge clk);
    if (rst) begin
      for (int j = 0; j <= DB + 1; j++) hist[j] = '1;
      m_stable = '1;
      m_latch  = '0;
      m_cond   = '1;
      m_cambio = 1'b0;
    end else begin
      for (int j = DB + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = raw_n;
      ns = m_stable;
      for (int c = 0; c < N_CH; c++) begin
        all_diff = 1'b1;
        for (int j = 2; j <= DB + 1; j++)
          if (hist[j][c] == m_stable[c]) all_diff = 1'b0;
        if (all_diff) ns[c] = ~m_stable[c];
      end
      nl = (m_stable & ~ns & BTN) | (m_latch & ~{N_CH{clr_req}});
      nc = (BTN & ~nl) | (~BTN & ns);
      m_cambio = (nc != m_cond);
      m_cond   = nc;
      m_stable = ns;
      m_latch  = nl;
    end
    #1;
    chk("model_cond_n", {2'b00, cond_n}, {2'b00, m_cond});
    chk("model_cambio", {7'd0, cambio}, {7'd0, m_cambio});
  endtask

  task automatic measure(input int ch, input logic lvl, input int max_e,
                         output int hit_e, output int pulses);
    hit_e  = 0;
    pulses = 0;
    for (int e = 1; e <= max_e; e++) begin
      step();
      if (cambio) pulses++;
      if (hit_e == 0 && cond_n[ch] === lvl) hit_e = e;
    end
  endtask

  initial begin
    int hit, pulses, bad, idx, fall, rise;
    rst = 1'b1; raw_n = '0; clr_req = 1'b0;

    // Reset with all inputs asserted
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_cond_n", {2'b00, cond_n}, 8'h3F);
      chk("rst_cambio", {7'd0, cambio}, 8'h00);
    end
    rst = 1'b0; raw_n = '1;
    repeat (3) step();
    $display("reset: cond_n=%b cambio=%b", cond_n, cambio);

    // Level channel latency
    raw_n[0] = 1'b0;
    measure(0, 1'b0, 10, hit, pulses);
    chk("hm_fall_edge", 8'(hit), 8'd6);
    chk("hm_fall_pulses", 8'(pulses), 8'd1);
    raw_n[0] = 1'b1;
    measure(0, 1'b1, 10, hit, pulses);
    chk("hm_rise_edge", 8'(hit), 8'd6);
    chk("hm_rise_pulses", 8'(pulses), 8'd1);
    $display("level latency: fall/rise checked on ch0");

    // Short glitch rejected
    raw_n[1] = 1'b0;
    bad = 0; pulses = 0;
    for (int e = 1; e <= 13; e++) begin
      if (e == 4) raw_n[1] = 1'b1;
      step();
      if (cond_n !== 6'h3F) bad++;
      if (cambio) pulses++;
    end
    chk("glitch_cond", 8'(bad), 8'd0);
    chk("glitch_cambio", 8'(pulses), 8'd0);

    // 5-cycle pulse accepted
    raw_n[1] = 1'b0;
    fall = 0; rise = 0;
    for (int e = 1; e <= 14; e++) begin
      if (e == 6) raw_n[1] = 1'b1;
      step();
      if (fall == 0 && cond_n[1] === 1'b0) fall = e;
      if (fall != 0 && rise == 0 && cond_n[1] === 1'b1) rise = e;
    end
    chk("pulse5_fall_edge", 8'(fall), 8'd6);
    chk("pulse5_rise_edge", 8'(rise), 8'd11);
    $display("glitch: 3-cycle rejected, 5-cycle accepted on ch1");

    // Button latch holds after release, cleared by clr_req
    raw_n[2] = 1'b0;
    repeat (8) step();
    raw_n[2] = 1'b1;
    repeat (10) step();
    chk("bp_latched", {7'd0, cond_n[2]}, 8'd0);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    chk("bp_cleared", {7'd0, cond_n[2]}, 8'd1);
    chk("bp_clear_cambio", {7'd0, cambio}, 8'd1);
    step();
    chk("bp_cambio_single", {7'd0, cambio}, 8'd0);
    $display("button latch: set, held, cleared on ch2");

    // Clear on the same edge as the debounced press
    raw_n[3] = 1'b0;
    repeat (5) step();
    chk("bb_pre_press", {7'd0, cond_n[3]}, 8'd1);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    chk("bb_collision_set", {7'd0, cond_n[3]}, 8'd0);
    raw_n[3] = 1'b1;
    repeat (8) step();
    chk("bb_hold_after_release", {7'd0, cond_n[3]}, 8'd0);
    $display("collision: press beats clear on ch3");

    // Reset mid-debounce, input held low across release
    raw_n[5] = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("midrst_cond_n", {2'b00, cond_n}, 8'h3F);
    chk("midrst_cambio", {7'd0, cambio}, 8'd0);
    rst = 1'b0;
    measure(5, 1'b0, 10, hit, pulses);
    chk("midrst_fall_edge", 8'(hit), 8'd6);
    $display("mid-debounce reset: ch5 re-debounced");

    // Randomized traffic against the model
    raw_n[5] = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = int'($urandom_range(0, N_CH - 1));
        raw_n[idx] = ~raw_n[idx];
      end
      clr_req = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; clr_req = 1'b0;
    $display("random: 3000 cycles compared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
